// File: rtl/ser_pkg.sv
// Shared types and constants for the serial bit feeder: FSM encoding,
// gap counter width and the default word width.
`timescale 1ns/1ps
package ser_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int GAP_CW    = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_PAR   = 2'b10,
        S_GAP   = 2'b11
    } ser_state_e;

endpackage

// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial front end of the sequence recognizer: MSB-first bits with
// qualifier and end-of-word marker. Define SER_PARITY_EN to append an even-parity bit.
`timescale 1ns/1ps
module serial_bit_feeder
    import ser_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int GAP   = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             x,
    output logic             x_valid,
    output logic             x_last,
    output logic             busy
);

    localparam int                CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]     CNT_LOAD = CW'(WIDTH - 1);
    localparam bit                HAS_GAP  = (GAP > 0);
    localparam logic [GAP_CW-1:0] GAP_LOAD = HAS_GAP ? GAP_CW'(GAP - 1) : '0;

    ser_state_e        state_q, state_d;
    logic [WIDTH-1:0]  shift_q, shift_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [GAP_CW-1:0] gap_q, gap_d;
    logic              last_bit;
    logic              word_end;
    logic              accept;
`ifdef SER_PARITY_EN
    logic              par_q, par_d;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            gap_q   <= '0;
`ifdef SER_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
`ifdef SER_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        gap_d    = gap_q;
        last_bit = (state_q == S_SHIFT) && (cnt_q == '0);
`ifdef SER_PARITY_EN
        par_d    = par_q;
        word_end = (state_q == S_PAR);
        x_valid  = (state_q == S_SHIFT) || (state_q == S_PAR);
        x        = (state_q == S_SHIFT) ? shift_q[WIDTH-1] :
                   (state_q == S_PAR)   ? par_q : 1'b0;
`else
        word_end = last_bit;
        x_valid  = (state_q == S_SHIFT);
        x        = (state_q == S_SHIFT) ? shift_q[WIDTH-1] : 1'b0;
`endif
        x_last   = word_end;
        busy     = (state_q != S_IDLE);
        // With no gap the final bit cycle doubles as the accept slot, so words abut.
        in_ready = (state_q == S_IDLE) || (word_end && !HAS_GAP);
        accept   = in_valid && in_ready;

        case (state_q)
            S_SHIFT: begin
                shift_d = shift_q << 1;
                cnt_d   = cnt_q - CW'(1);
`ifdef SER_PARITY_EN
                if (last_bit) state_d = S_PAR;
`endif
            end
            S_GAP: begin
                if (gap_q == '0) state_d = S_IDLE;
                else             gap_d   = gap_q - GAP_CW'(1);
            end
            default: ;
        endcase

        if (word_end) begin
            if (HAS_GAP) begin
                state_d = S_GAP;
                gap_d   = GAP_LOAD;
            end else begin
                state_d = S_IDLE;
            end
        end

        if (accept) begin
            state_d = S_SHIFT;
            shift_d = in_data;
            cnt_d   = CNT_LOAD;
`ifdef SER_PARITY_EN
            par_d   = ^in_data;
`endif
        end
    end

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Scoreboard bench for serial_bit_feeder: a GAP=0 instance and a GAP=2 instance,
// expected bits queued at issue time and popped by per-instance monitors.
`timescale 1ns/1ps
module tb_serial_bit_feeder;

`ifdef SER_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int NB = 8 + PB;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data0, data1;
    logic       in_valid0, in_valid1;
    logic       in_ready0, x0, x_valid0, x_last0, busy0;
    logic       in_ready1, x1, x_valid1, x_last1, busy1;
    logic       mon_en;

    int total = 0;
    int bad   = 0;

    logic [1:0] q0[$];
    logic [1:0] q1[$];

    always #5 clk = ~clk;

    serial_bit_feeder #(.WIDTH(8), .GAP(0)) u_dut0 (
        .clock(clk), .reset(reset), .in_data(data0), .in_valid(in_valid0),
        .in_ready(in_ready0), .x(x0), .x_valid(x_valid0), .x_last(x_last0), .busy(busy0)
    );

    serial_bit_feeder #(.WIDTH(8), .GAP(2)) u_dut1 (
        .clock(clk), .reset(reset), .in_data(data1), .in_valid(in_valid1),
        .in_ready(in_ready1), .x(x1), .x_valid(x_valid1), .x_last(x_last1), .busy(busy1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Expected line entries are {x_last, x}, MSB first, parity bit appended when enabled.
    function automatic void push_word(input bit which, input logic [7:0] w);
        logic [1:0] e;
        for (int i = 7; i >= 0; i--) begin
            e = {(i == 0) && (PB == 0), w[i]};
            if (which) q1.push_back(e); else q0.push_back(e);
        end
        if (PB != 0) begin
            e = {1'b1, ^w};
            if (which) q1.push_back(e); else q0.push_back(e);
        end
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            if (x_valid0) begin
                if (q0.size() == 0) begin
                    total++; bad++;
                    $display("FAIL u0_extra_bit actual={%b,%b} required=none at %0t", x_last0, x0, $time);
                end else begin
                    check("u0_bit", {30'd0, x_last0, x0}, {30'd0, q0.pop_front()});
                end
            end else begin
                check("u0_idle_line", {30'd0, x_last0, x0}, 32'd0);
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (x_valid1) begin
                if (q1.size() == 0) begin
                    total++; bad++;
                    $display("FAIL u1_extra_bit actual={%b,%b} required=none at %0t", x_last1, x1, $time);
                end else begin
                    check("u1_bit", {30'd0, x_last1, x1}, {30'd0, q1.pop_front()});
                end
            end else begin
                check("u1_idle_line", {30'd0, x_last1, x1}, 32'd0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send0(input logic [7:0] w);
        in_valid0 = 1'b1;
        data0     = w;
        push_word(1'b0, w);
        step();
        in_valid0 = 1'b0;
        repeat (NB + 2) step();
        check("send_idle", {31'd0, busy0}, 32'd0);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; mon_en = 1'b0;
        in_valid0 = 1'b0; data0 = '0;
        in_valid1 = 1'b0; data1 = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0; mon_en = 1'b1;

        // reset state
        @(negedge clk);
        check("rst_ready0", {31'd0, in_ready0}, 32'd1);
        check("rst_busy0",  {31'd0, busy0},     32'd0);
        check("rst_xv0",    {31'd0, x_valid0},  32'd0);
        check("rst_ready1", {31'd0, in_ready1}, 32'd1);
        check("rst_busy1",  {31'd0, busy1},     32'd0);

        // single word A5
        in_valid0 = 1'b1; data0 = 8'hA5; push_word(1'b0, 8'hA5);
        step();
        in_valid0 = 1'b0;
        for (int k = 1; k <= NB + 1; k++) begin
            @(negedge clk);
            check("a5_xvalid", {31'd0, x_valid0},  {31'd0, k <= NB});
            check("a5_ready",  {31'd0, in_ready0}, {31'd0, k >= NB});
            check("a5_busy",   {31'd0, busy0},     {31'd0, k <= NB});
        end

        // back-to-back 0F then F0, in_valid held
        check("b2b_ready_c0", {31'd0, in_ready0}, 32'd1);
        in_valid0 = 1'b1; data0 = 8'h0F;
        push_word(1'b0, 8'h0F); push_word(1'b0, 8'hF0);
        step();
        data0 = 8'hF0;
        for (int k = 1; k <= 2 * NB + 1; k++) begin
            @(negedge clk);
            check("b2b_xvalid", {31'd0, x_valid0},  {31'd0, k <= 2 * NB});
            check("b2b_ready",  {31'd0, in_ready0}, {31'd0, (k == NB) || (k >= 2 * NB)});
            if (k == NB) begin
                @(posedge clk); #1;
                in_valid0 = 1'b0;
            end
        end
        step();

        // in_data/in_valid wander while in_ready=0; only 3C then 5A are emitted
        in_valid0 = 1'b1; data0 = 8'h3C; push_word(1'b0, 8'h3C);
        step();
        for (int k = 1; k <= NB - 1; k++) begin
            data0     = 8'(k * 37);
            in_valid0 = k[0];
            step();
        end
        in_valid0 = 1'b1; data0 = 8'h5A; push_word(1'b0, 8'h5A);
        step();
        in_valid0 = 1'b0;
        repeat (NB + 1) step();
        check("chg_idle", {31'd0, busy0}, 32'd0);

        // parity-relevant words
        send0(8'h07);
        send0(8'h03);

        // reset in cycle 3 of C3
        in_valid0 = 1'b1; data0 = 8'hC3; push_word(1'b0, 8'hC3);
        step();
        in_valid0 = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst_mid_leftover", q0.size(), NB - 3);
        q0.delete();
        in_valid0 = 1'b1; data0 = 8'h81; push_word(1'b0, 8'h81);
        @(negedge clk);
        check("rst_mid_xvalid", {31'd0, x_valid0},  32'd0);
        check("rst_mid_x",      {31'd0, x0},        32'd0);
        check("rst_mid_busy",   {31'd0, busy0},     32'd0);
        check("rst_mid_ready",  {31'd0, in_ready0}, 32'd1);
        step();
        in_valid0 = 1'b0;
        @(negedge clk);
        check("rst_mid_restart", {31'd0, x_valid0}, 32'd1);
        repeat (NB + 1) step();
        check("rst_mid_idle", {31'd0, busy0}, 32'd0);

        // reset and in_valid together: word dropped
        reset = 1'b1; in_valid0 = 1'b1; data0 = 8'hFF;
        step();
        reset = 1'b0; in_valid0 = 1'b0;
        @(negedge clk);
        check("rst_win_busy",   {31'd0, busy0},    32'd0);
        check("rst_win_xvalid", {31'd0, x_valid0}, 32'd0);
        step();
        check("rst_win_busy2",  {31'd0, busy0},    32'd0);

        // GAP=2 instance: FF then 00
        in_valid1 = 1'b1; data1 = 8'hFF; push_word(1'b1, 8'hFF);
        step();
        data1 = 8'h00; push_word(1'b1, 8'h00);
        for (int k = 1; k <= NB + 4; k++) begin
            @(negedge clk);
            check("gap_xvalid", {31'd0, x_valid1},  {31'd0, (k <= NB) || (k == NB + 4)});
            check("gap_ready",  {31'd0, in_ready1}, {31'd0, k == NB + 3});
            check("gap_busy",   {31'd0, busy1},     {31'd0, k != NB + 3});
            if (k == NB + 3) begin
                @(posedge clk); #1;
                in_valid1 = 1'b0;
            end
        end
        repeat (NB + 4) step();
        check("gap_idle", {31'd0, busy1}, 32'd0);

        check("q0_drained", q0.size(), 32'd0);
        check("q1_drained", q1.size(), 32'd0);
        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
